// File: rtl/flit_vc_arbiter_pkg.sv
// Shared types and helpers for the per-VC flit arbiter.
// FLIT_WIDTH mirrors the router-wide flit width.
package flit_vc_arbiter_pkg;

  localparam int FLIT_WIDTH = 16;

  function automatic int credits_of(input int log_credits);
    return 1 << log_credits;
  endfunction

endpackage

// File: rtl/flit_vc_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request after ptr wins.
// Also reused by the output-side allocator.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flit_vc_arbiter.sv
// Per-VC flit arbiter with credit tracking and a one-entry
// output register toward the crossbar/link stage.
module flit_vc_arbiter
  import flit_vc_arbiter_pkg::*;
#(
  parameter int LOG_NVCS    = 1,
  parameter int LOG_CREDITS = 3,
  localparam int NVCS       = 1 << LOG_NVCS,
  localparam int CW         = LOG_CREDITS + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       error,
  output logic                       is_quiescent,
  input  logic [NVCS*FLIT_WIDTH-1:0] flit_in,
  input  logic [NVCS-1:0]            flit_in_valid,
  output logic [NVCS-1:0]            dequeue,
  output logic [FLIT_WIDTH-1:0]      flit_out,
  output logic [LOG_NVCS-1:0]        flit_out_vc,
  output logic                       flit_out_valid,
  input  logic                       flit_out_ack,
  input  logic                       credit_in_valid,
  input  logic [LOG_NVCS-1:0]        credit_in_vc,
  output logic                       credit_ack
);

  localparam logic [CW-1:0] CREDITS = CW'(credits_of(LOG_CREDITS));

  logic [CW-1:0]         cnt_q [NVCS];
  logic [CW-1:0]         cnt_d [NVCS];
  logic [LOG_NVCS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic [LOG_NVCS-1:0]   vc_q, vc_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic [NVCS-1:0]     eligible, arb_gnt, gnt;
  logic [LOG_NVCS-1:0] winner;
  logic                slot_free, grant, ret, all_full;

  rr_arbiter #(.N(NVCS), .PW(LOG_NVCS)) u_rr (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    eligible = '0;
    winner   = '0;
    all_full = 1'b1;
    for (int v = 0; v < NVCS; v++) begin
      eligible[v] = flit_in_valid[v] & (cnt_q[v] != '0);
      if (arb_gnt[v]) winner = LOG_NVCS'(v);
      if (cnt_q[v] != CREDITS) all_full = 1'b0;
    end
    slot_free = ~valid_q | flit_out_ack;
    grant     = ~reset & enable & slot_free & (|eligible);
    gnt       = grant ? arb_gnt : '0;
    ret       = ~reset & enable & credit_in_valid;
  end

  // A return and a grant on the same VC cancel out.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    flit_d   = flit_q;
    vc_d     = vc_q;
    valid_d  = valid_q;
    error_d  = error_q;
    for (int v = 0; v < NVCS; v++) begin
      cnt_d[v] = cnt_q[v];
      if (ret && credit_in_vc == LOG_NVCS'(v)) begin
        if (!gnt[v]) begin
          if (cnt_q[v] == CREDITS) error_d = 1'b1;
          else cnt_d[v] = cnt_q[v] + 1'b1;
        end
      end else if (gnt[v]) begin
        cnt_d[v] = cnt_q[v] - 1'b1;
      end
    end
    if (enable && flit_out_ack && !valid_q) error_d = 1'b1;
    if (grant) begin
      flit_d   = flit_in[winner*FLIT_WIDTH +: FLIT_WIDTH];
      vc_d     = winner;
      valid_d  = 1'b1;
      rr_ptr_d = winner;
    end else if (enable && flit_out_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= LOG_NVCS'(NVCS - 1);
      flit_q   <= '0;
      vc_q     <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      for (int v = 0; v < NVCS; v++) cnt_q[v] <= CREDITS;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      flit_q   <= flit_d;
      vc_q     <= vc_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      for (int v = 0; v < NVCS; v++) cnt_q[v] <= cnt_d[v];
    end
  end

  assign dequeue        = gnt;
  assign credit_ack     = ret;
  assign flit_out       = flit_q;
  assign flit_out_vc    = vc_q;
  assign flit_out_valid = valid_q;
  assign error          = error_q;
  assign is_quiescent   = ~valid_q & all_full;

endmodule

// File: tb/tb_flit_vc_arbiter.sv
// Directed bench for flit_vc_arbiter (2 VCs, 8 credits each).
module tb_flit_vc_arbiter;
  import flit_vc_arbiter_pkg::*;

  localparam logic [15:0] FA = 16'hAAAA;
  localparam logic [15:0] FB = 16'hBBBB;
  localparam logic [15:0] FC = 16'hCCCC;

  logic        clock, reset, enable;
  logic        error, is_quiescent;
  logic [31:0] flit_in;
  logic [1:0]  flit_in_valid, dequeue;
  logic [15:0] flit_out;
  logic        flit_out_vc, flit_out_valid, flit_out_ack;
  logic        credit_in_valid, credit_in_vc, credit_ack;
  logic        ack_en, ack_force;

  int total = 0;
  int bad   = 0;
  int n;

  assign flit_out_ack = (ack_en & flit_out_valid) | ack_force;

  flit_vc_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .error           (error),
    .is_quiescent    (is_quiescent),
    .flit_in         (flit_in),
    .flit_in_valid   (flit_in_valid),
    .dequeue         (dequeue),
    .flit_out        (flit_out),
    .flit_out_vc     (flit_out_vc),
    .flit_out_valid  (flit_out_valid),
    .flit_out_ack    (flit_out_ack),
    .credit_in_valid (credit_in_valid),
    .credit_in_vc    (credit_in_vc),
    .credit_ack      (credit_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic credit(input logic vc, input int k);
    for (int i = 0; i < k; i++) begin
      credit_in_valid = 1'b1;
      credit_in_vc    = vc;
      step();
    end
    credit_in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    flit_in = {FB, FA}; flit_in_valid = 2'b00;
    ack_en = 1'b0; ack_force = 1'b0;
    credit_in_valid = 1'b0; credit_in_vc = 1'b0;
    #3;
    chk("rst_deq", dequeue, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_valid", flit_out_valid, 1'b0);
    chk("rst_flit", flit_out, 16'h0);
    chk("rst_vc", flit_out_vc, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_quiet", is_quiescent, 1'b1);
    chk("rst_cack", credit_ack, 1'b0);

    // both VCs, VC0 first then VC1 back to back
    flit_in_valid = 2'b11; ack_en = 1'b1;
    #1 chk("rr_deq0", dequeue, 2'b01);
    step();
    chk("rr_out0", flit_out, FA);
    chk("rr_vc0", flit_out_vc, 1'b0);
    chk("rr_deq1", dequeue, 2'b10);
    step();
    chk("rr_out1", flit_out, FB);
    chk("rr_vc1", flit_out_vc, 1'b1);
    chk("rr_val1", flit_out_valid, 1'b1);
    flit_in_valid = 2'b00;
    step();
    chk("drain_val", flit_out_valid, 1'b0);
    chk("not_quiet", is_quiescent, 1'b0);
    credit(1'b0, 1);
    credit(1'b1, 1);
    chk("ret_err", error, 1'b0);
    chk("ret_quiet", is_quiescent, 1'b1);

    // credit exhaustion on VC0
    flit_in_valid = 2'b01;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (dequeue[0]) n++;
      step();
    end
    chk("exh_count", n, 8);
    chk("exh_deq", dequeue, 2'b00);
    chk("exh_val", flit_out_valid, 1'b0);
    credit_in_valid = 1'b1; credit_in_vc = 1'b0;
    #1 chk("cack", credit_ack, 1'b1);
    step();
    credit_in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (dequeue[0]) n++;
      step();
    end
    chk("one_more", n, 1);

    // VC0 out of credit never blocks VC1
    flit_in_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hol_deq", dequeue, 2'b10);
      step();
    end
    credit_in_valid = 1'b1; credit_in_vc = 1'b0;
    #1 chk("hol_deq5", dequeue, 2'b10);
    step();
    credit_in_valid = 1'b0;
    chk("hol_vc0", dequeue, 2'b01);
    step();
    flit_in_valid = 2'b00;
    step();
    step();
    credit(1'b0, 8);
    credit(1'b1, 5);
    chk("hol_err", error, 1'b0);
    chk("hol_quiet", is_quiescent, 1'b1);

    // stall with ack low, then back-to-back reload
    flit_in_valid = 2'b10; ack_en = 1'b0;
    #1 chk("st_deq", dequeue, 2'b10);
    step();
    flit_in = {FC, FA};
    for (int i = 0; i < 5; i++) begin
      chk("st_hold", {dequeue, flit_out}, {2'b00, FB});
      step();
    end
    ack_en = 1'b1;
    #1 chk("st_ackdeq", dequeue, 2'b10);
    step();
    chk("st_new", {flit_out_valid, flit_out}, {1'b1, FC});
    flit_in_valid = 2'b00;
    step();
    chk("st_drain", flit_out_valid, 1'b0);

    // grant and return on VC1 in the same cycle
    flit_in_valid = 2'b10;
    credit_in_valid = 1'b1; credit_in_vc = 1'b1;
    #1 chk("net_deq", dequeue, 2'b10);
    step();
    credit_in_valid = 1'b0; flit_in_valid = 2'b00;
    step();
    credit(1'b1, 2);
    chk("net_err", error, 1'b0);
    chk("net_quiet", is_quiescent, 1'b1);

    // enable low freezes everything
    enable = 1'b0; flit_in_valid = 2'b11;
    credit_in_valid = 1'b1; credit_in_vc = 1'b0;
    ack_force = 1'b1;
    #1 chk("en_deq", dequeue, 2'b00);
    chk("en_cack", credit_ack, 1'b0);
    step();
    step();
    ack_force = 1'b0; credit_in_valid = 1'b0;
    chk("en_state", {error, is_quiescent, flit_out_valid, flit_out},
        {1'b0, 1'b1, 1'b0, FC});
    enable = 1'b1; ack_en = 1'b0;
    #1 chk("en_deq0", dequeue, 2'b01);
    step();
    chk("en_out", {flit_out_valid, flit_out_vc, flit_out}, {1'b1, 1'b0, FA});

    // overflow return sets sticky error
    credit(1'b1, 1);
    chk("ovf_err", error, 1'b1);
    step();
    chk("ovf_sticky", error, 1'b1);

    // async reset mid-cycle
    #2 reset = 1'b1;
    #1 chk("arst", {flit_out_valid, flit_out, error, dequeue},
           {1'b0, 16'h0, 1'b0, 2'b00});
    @(negedge clock);
    reset = 1'b0; flit_in_valid = 2'b00;
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    chk("ack_err", error, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
